// File: rtl/enc_period_meas_pkg.sv
// rtl/enc_period_meas_pkg.sv - shared period width, saturation value, state encoding, quadrature helper
package enc_period_meas_pkg;

  localparam int ENC_PERIOD_W = 26;
  localparam logic [ENC_PERIOD_W-1:0] ENC_SAT = 26'h3FFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MEAS  = 2'd1,
    ST_STALL = 2'd2
  } enc_state_e;

  // Forward successor of a {B,A} pair in the Gray sequence 00->01->11->10
  function automatic logic [1:0] quad_next(input logic [1:0] ba);
    case (ba)
      2'b00:   quad_next = 2'b01;
      2'b01:   quad_next = 2'b11;
      2'b11:   quad_next = 2'b10;
      default: quad_next = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// rtl/enc_input_filter.sv - 2-FF synchronizer plus FILT_LEN-cycle stability filter for one encoder pin
module enc_input_filter
  import enc_period_meas_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic filt_o
);

  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;

  // cnt_q counts consecutive cycles in which the synchronized level disagrees with filt_q
  always_comb begin
    filt_d = filt_q;
    cnt_d  = 4'd0;
    if (sync2_q != filt_q) begin
      if (cnt_q == 4'(FILT_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/enc_period_meas.sv
// rtl/enc_period_meas.sv - quadrature position tracking and channel-A period measurement with ready strobe
module enc_period_meas
  import enc_period_meas_pkg::*;
#(
  parameter int                      CLK_DIV  = 1,
  parameter int                      FILT_LEN = 3,
  parameter logic [ENC_PERIOD_W-1:0] SAT_VAL  = ENC_SAT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    enable,
  input  logic                    err_clr,
  output logic [ENC_PERIOD_W-1:0] enc_fb,
  output logic                    enc_dir_fb,
  output logic                    enc_val_ready,
  output logic [31:0]             enc_pos,
  output logic                    enc_err
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic                    a_f, b_f;
  enc_state_e              state_q, state_d;
  logic                    a_prev_q, b_prev_q;
  logic [PW-1:0]           presc_q, presc_d;
  logic [ENC_PERIOD_W-1:0] cnt_q, cnt_d, fb_q, fb_d;
  logic                    dir_q, dir_d, dir_fb_q, dir_fb_d, rdy_q, rdy_d, err_q, err_d;
  logic [31:0]             pos_q, pos_d;
  logic                    edge_a, edge_dir, tick;
  logic [1:0]              ba_prev, ba_cur;

  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk_i(clk), .rst_i(reset), .pin_i(enc_a), .filt_o(a_f)
  );
  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk_i(clk), .rst_i(reset), .pin_i(enc_b), .filt_o(b_f)
  );

  assign ba_prev  = {b_prev_q, a_prev_q};
  assign ba_cur   = {b_f, a_f};
  assign edge_a   = a_f & ~a_prev_q;
  assign edge_dir = ~b_f;
  assign tick     = (presc_q == PW'(CLK_DIV - 1));

  always_comb begin
    pos_d = pos_q;
    err_d = err_q & ~err_clr;
    if (ba_cur != ba_prev) begin
      if (ba_cur == ~ba_prev) begin
        err_d = 1'b1;
      end else if (ba_cur == quad_next(ba_prev)) begin
        pos_d = pos_q + 32'd1;
      end else begin
        pos_d = pos_q - 32'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    presc_d  = tick ? '0 : presc_q + PW'(1);
    dir_d    = dir_q;
    fb_d     = fb_q;
    dir_fb_d = dir_fb_q;
    rdy_d    = 1'b0;
    if (tick && (cnt_q != SAT_VAL)) begin
      cnt_d = cnt_q + ENC_PERIOD_W'(1);
    end
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (edge_a) begin
            state_d = ST_MEAS;
            cnt_d   = ENC_PERIOD_W'(1);
            presc_d = '0;
            dir_d   = edge_dir;
          end
        end
        ST_MEAS: begin
          if (edge_a) begin
            rdy_d    = 1'b1;
            fb_d     = (edge_dir == dir_q) ? cnt_q : SAT_VAL;
            dir_fb_d = edge_dir;
            cnt_d    = ENC_PERIOD_W'(1);
            presc_d  = '0;
            dir_d    = edge_dir;
          end else if ((cnt_q == SAT_VAL) && !rdy_q) begin
            // Stalled: publish the freeze value once; the strobe never repeats back-to-back
            rdy_d    = 1'b1;
            fb_d     = SAT_VAL;
            dir_fb_d = dir_q;
            state_d  = ST_STALL;
          end
        end
        ST_STALL: begin
          if (edge_a) begin
            state_d = ST_MEAS;
            cnt_d   = ENC_PERIOD_W'(1);
            presc_d = '0;
            dir_d   = edge_dir;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_prev_q <= 1'b0;
      b_prev_q <= 1'b0;
      presc_q  <= '0;
      cnt_q    <= '0;
      fb_q     <= SAT_VAL;
      dir_q    <= 1'b0;
      dir_fb_q <= 1'b0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      pos_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      a_prev_q <= a_f;
      b_prev_q <= b_f;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      fb_q     <= fb_d;
      dir_q    <= dir_d;
      dir_fb_q <= dir_fb_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      pos_q    <= pos_d;
    end
  end

  assign enc_fb        = fb_q;
  assign enc_dir_fb    = dir_fb_q;
  assign enc_val_ready = rdy_q;
  assign enc_pos       = pos_q;
  assign enc_err       = err_q;

endmodule

// File: tb/tb_enc_period_meas.sv
// tb/tb_enc_period_meas.sv - directed scoreboard bench for enc_period_meas
module tb_enc_period_meas;

  localparam int          LAT = 6;
  localparam logic [25:0] SAT = 26'd5000;

  typedef struct packed {
    logic [25:0] fb;
    logic        dir;
    int          at;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic        enable = 1'b0;
  logic        err_clr = 1'b0;
  logic [25:0] enc_fb;
  logic        enc_dir_fb;
  logic        enc_val_ready;
  logic [31:0] enc_pos;
  logic        enc_err;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          exp_pos = 0;
  int          last_rise = 0;
  logic [25:0] last_fb = '0;
  logic        prev_rdy = 1'b0;
  exp_t        exp_q[$];
  exp_t        e;

  enc_period_meas #(.CLK_DIV(1), .FILT_LEN(3), .SAT_VAL(SAT)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enable(enable),
    .err_clr(err_clr), .enc_fb(enc_fb), .enc_dir_fb(enc_dir_fb),
    .enc_val_ready(enc_val_ready), .enc_pos(enc_pos), .enc_err(enc_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at cyc %0d: observed %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [25:0] fb, input logic dir, input int at);
    exp_t x;
    x.fb  = fb;
    x.dir = dir;
    x.at  = at;
    exp_q.push_back(x);
  endtask

  // One quadrature period; fwd = A leads B. A strobe is expected LAT cycles after A rises when push=1
  task automatic quad_period(input int p, input bit fwd, input bit push, input logic [25:0] fb);
    int q = p / 4;
    if (fwd) begin
      enc_a = 1'b1; last_rise = cyc;
      if (push) push_exp(fb, 1'b1, cyc + LAT);
      wait_cyc(q); enc_b = 1'b1;
      wait_cyc(q); enc_a = 1'b0;
      wait_cyc(q); enc_b = 1'b0;
      wait_cyc(q);
      exp_pos += 4;
    end else begin
      enc_b = 1'b1;
      wait_cyc(q); enc_a = 1'b1; last_rise = cyc;
      if (push) push_exp(fb, 1'b0, cyc + LAT);
      wait_cyc(q); enc_b = 1'b0;
      wait_cyc(q); enc_a = 1'b0;
      wait_cyc(q);
      exp_pos -= 4;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      last_fb  = enc_fb;
      prev_rdy = 1'b0;
    end else begin
      if (enc_val_ready) begin
        chk("strobe_not_back_to_back", {31'd0, prev_rdy}, 32'd0);
        chk("strobe_expected", exp_q.size(), (exp_q.size() != 0) ? exp_q.size() : 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("strobe_fb", {6'd0, enc_fb}, {6'd0, e.fb});
          chk("strobe_dir", {31'd0, enc_dir_fb}, {31'd0, e.dir});
          chk("strobe_cycle", cyc, e.at);
        end
      end else begin
        chk("fb_stable_without_strobe", {6'd0, enc_fb}, {6'd0, last_fb});
      end
      last_fb  = enc_fb;
      prev_rdy = enc_val_ready;
    end
  end

  initial begin
    wait_cyc(3);
    chk("reset_fb", {6'd0, enc_fb}, {6'd0, SAT});
    chk("reset_dir", {31'd0, enc_dir_fb}, 32'd0);
    chk("reset_ready", {31'd0, enc_val_ready}, 32'd0);
    chk("reset_pos", enc_pos, 32'd0);
    chk("reset_err", {31'd0, enc_err}, 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    wait_cyc(5);

    // Forward 1000-cycle periods: first edge only arms the measurement
    quad_period(1000, 1'b1, 1'b0, 26'd0);
    repeat (3) quad_period(1000, 1'b1, 1'b1, 26'd1000);
    chk("fwd_pos", enc_pos, 32'd16);

    // Reversal: first reverse edge publishes the freeze value
    quad_period(600, 1'b0, 1'b1, SAT);
    repeat (2) quad_period(600, 1'b0, 1'b1, 26'd600);
    chk("rev_pos", enc_pos, 32'(exp_pos));

    // Stall: one freeze strobe after SAT ticks, then nothing
    push_exp(SAT, 1'b0, last_rise + LAT + 5000);
    wait_cyc(5000);
    wait_cyc(2000);
    chk("stall_strobe_seen", exp_q.size(), 32'd0);
    quad_period(800, 1'b1, 1'b0, 26'd0);
    repeat (2) quad_period(800, 1'b1, 1'b1, 26'd800);
    chk("resume_pos", enc_pos, 32'(exp_pos));
    enable = 1'b0;
    wait_cyc(5);

    // Short glitch on A must not reach the filtered level
    enable = 1'b1;
    wait_cyc(5);
    enc_a = 1'b1;
    wait_cyc(2);
    enc_a = 1'b0;
    wait_cyc(20);
    chk("glitch_pos", enc_pos, 32'(exp_pos));
    chk("glitch_no_err", {31'd0, enc_err}, 32'd0);

    // Both channels toggling together is illegal
    enable = 1'b0;
    enc_a = 1'b1; enc_b = 1'b1;
    wait_cyc(10);
    chk("illegal_err_set", {31'd0, enc_err}, 32'd1);
    chk("illegal_pos", enc_pos, 32'(exp_pos));
    enc_a = 1'b0; enc_b = 1'b0;
    wait_cyc(10);
    chk("illegal_err_sticky", {31'd0, enc_err}, 32'd1);
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    wait_cyc(2);
    chk("err_cleared", {31'd0, enc_err}, 32'd0);

    // Reset 400 cycles into a measured period
    enable = 1'b1;
    wait_cyc(5);
    quad_period(1000, 1'b1, 1'b0, 26'd0);
    enc_a = 1'b1;
    push_exp(26'd1000, 1'b1, cyc + LAT);
    wait_cyc(250);
    enc_b = 1'b1;
    wait_cyc(150);
    chk("pre_reset_fb", {6'd0, enc_fb}, 32'd1000);
    reset = 1'b1;
    #1;
    chk("midreset_fb", {6'd0, enc_fb}, {6'd0, SAT});
    chk("midreset_dir", {31'd0, enc_dir_fb}, 32'd0);
    chk("midreset_ready", {31'd0, enc_val_ready}, 32'd0);
    chk("midreset_pos", enc_pos, 32'd0);
    chk("midreset_err", {31'd0, enc_err}, 32'd0);
    exp_pos = 0;
    enc_a = 1'b0; enc_b = 1'b0;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(20);
    chk("post_reset_pos", enc_pos, 32'd0);

    // Disabled: position still tracks, no strobes
    enable = 1'b0;
    repeat (2) quad_period(400, 1'b1, 1'b0, 26'd0);
    wait_cyc(10);
    chk("disabled_pos", enc_pos, 32'd8);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
